// File: rtl/led_scan_scheduler_pkg.sv
// Shared types and helpers for the LED scan scheduler.
// Provides the phase enum, the character width, the all-off anode pattern
// and the active-low one-hot anode decode used by the scheduler.
package led_scan_scheduler_pkg;

    localparam int CHAR_W = 4;
    localparam logic [3:0] ANODES_OFF = 4'b1111;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_e;

    // Digit index 3 drives an3 (leftmost), index 0 drives an0.
    function automatic logic [3:0] anode_pattern(input logic [1:0] digit);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << digit;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/led_scan_scheduler_msg_buffer.sv
// Message character buffer: MSG_LEN x CHAR_W register file.
// Ports: clk, reset (async active-low clear of every entry),
//        wr_en/wr_addr/wr_data (single write port),
//        rd_addr/rd_data (asynchronous read port).
module msg_buffer
    import led_scan_scheduler_pkg::*;
#(
    parameter int MSG_LEN = 16,
    parameter int AW      = $clog2(MSG_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [CHAR_W-1:0] rd_data
);

    logic [CHAR_W-1:0] mem [MSG_LEN];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read sees the pre-edge contents, so a same-edge write is not visible
    // to a latch taken on that edge.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/led_scan_scheduler.sv
// Four-digit 7-segment scan scheduler.
// Each digit gets BLANK_CYCLES of all-anodes-off followed by DIGIT_CYCLES
// with its anode low. The character for a digit is latched on the edge that
// enters its blank slot, so it is settled before the anode falls. Optional
// scrolling advances the 4-character window every SCROLL_FRAMES frames.
// Ports: clk, reset (async active-low), wr_en/wr_addr/wr_data (buffer write),
//        scroll_en, an3..an0 (active-low anodes, an3 leftmost),
//        char (code for the LED decoder), frame_tick (last cycle of frame).
//
// state    | meaning
// PH_BLANK | all anodes high, char for the selected digit settling
// PH_ON    | anode of the selected digit low
module led_scan_scheduler
    import led_scan_scheduler_pkg::*;
#(
    parameter int DIGIT_CYCLES  = 64,
    parameter int BLANK_CYCLES  = 4,
    parameter int SCROLL_FRAMES = 16,
    parameter int MSG_LEN       = 16,
    parameter int AW            = $clog2(MSG_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic              scroll_en,
    output logic              an3,
    output logic              an2,
    output logic              an1,
    output logic              an0,
    output logic [CHAR_W-1:0] char,
    output logic              frame_tick
);

    localparam int PH_MAX = (BLANK_CYCLES > DIGIT_CYCLES) ? BLANK_CYCLES : DIGIT_CYCLES;
    localparam int CW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int FW     = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(SCROLL_FRAMES - 1);

    phase_e            phase, phase_nxt;
    logic [1:0]        digit, digit_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              latch;

    logic [FW-1:0]     frame_cnt, frame_cnt_nxt;
    logic [AW-1:0]     offset, offset_nxt;
    logic [1:0]        slot;
    logic [AW-1:0]     rd_addr;
    logic [CHAR_W-1:0] rd_data;

    logic [3:0]        an_q, an_nxt;
    logic [CHAR_W-1:0] char_q;
    logic              tick_q, tick_nxt;

    msg_buffer #(
        .MSG_LEN (MSG_LEN),
        .AW      (AW)
    ) u_msg_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= PH_BLANK;
            digit <= 2'd3;
            cnt   <= '0;
        end else begin
            phase <= phase_nxt;
            digit <= digit_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        phase_nxt = phase;
        digit_nxt = digit;
        cnt_nxt   = cnt + 1'b1;
        latch     = 1'b0;
        case (phase)
            PH_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    phase_nxt = PH_ON;
                    cnt_nxt   = '0;
                end
            end
            PH_ON: begin
                if (cnt == DIGIT_LAST) begin
                    phase_nxt = PH_BLANK;
                    cnt_nxt   = '0;
                    digit_nxt = digit - 2'd1;
                    latch     = 1'b1;
                end
            end
            default: begin
                phase_nxt = PH_BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are computed from the next state and registered, so they
    // line up with the state register and have no path from the inputs.
    always_comb begin
        an_nxt   = (phase_nxt == PH_ON) ? anode_pattern(digit_nxt) : ANODES_OFF;
        tick_nxt = (phase_nxt == PH_ON) && (digit_nxt == 2'd0) && (cnt_nxt == DIGIT_LAST);
    end

    // tick_q marks the last cycle of a frame; the offset step takes effect on
    // the same edge that latches digit 3, so a frame never mixes offsets.
    always_comb begin
        offset_nxt    = offset;
        frame_cnt_nxt = frame_cnt;
        if (!scroll_en) begin
            frame_cnt_nxt = '0;
        end else if (tick_q) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt_nxt = '0;
                offset_nxt    = offset + 1'b1;
            end else begin
                frame_cnt_nxt = frame_cnt + 1'b1;
            end
        end
        slot    = 2'd3 - digit_nxt;
        rd_addr = offset_nxt + AW'(slot);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            offset    <= '0;
            frame_cnt <= '0;
            an_q      <= ANODES_OFF;
            char_q    <= '0;
            tick_q    <= 1'b0;
        end else begin
            offset    <= offset_nxt;
            frame_cnt <= frame_cnt_nxt;
            an_q      <= an_nxt;
            tick_q    <= tick_nxt;
            if (latch) begin
                char_q <= rd_data;
            end
        end
    end

    assign {an3, an2, an1, an0} = an_q;
    assign char       = char_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_led_scan_scheduler.sv
module tb_led_scan_scheduler;

    localparam int DC    = 4;
    localparam int BC    = 2;
    localparam int SF    = 2;
    localparam int ML    = 8;
    localparam int SLOT  = DC + BC;
    localparam int FRAME = 4 * SLOT;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       scroll_en;
    logic       an3, an2, an1, an0;
    logic [3:0] char;
    logic       frame_tick;

    led_scan_scheduler #(
        .DIGIT_CYCLES  (DC),
        .BLANK_CYCLES  (BC),
        .SCROLL_FRAMES (SF),
        .MSG_LEN       (ML)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .scroll_en  (scroll_en),
        .an3        (an3),
        .an2        (an2),
        .an1        (an1),
        .an0        (an0),
        .char       (char),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: time since reset release plus buffer/offset shadow.
    int         t;
    logic [3:0] mchar;
    int         moff;
    int         mfc;
    logic [3:0] mbuf [ML];

    typedef struct {
        int         pos;
        logic [3:0] an;
        logic [3:0] ch;
        logic       ft;
    } vec_t;
    vec_t tbl [12];

    function automatic logic [3:0] exp_an(input int tt);
        int p, w, d;
        logic [3:0] one;
        one = 4'b0001;
        p = tt % FRAME;
        w = p % SLOT;
        if (w < BC) return 4'hF;
        d = 3 - p / SLOT;
        return ~(one << d);
    endfunction

    function automatic logic [3:0] anodes();
        return {an3, an2, an1, an0};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] an_now;
        an_now = anodes();
        check("anodes", an_now, exp_an(t));
        check("char", char, mchar);
        check("frame_tick", {3'b000, frame_tick}, ((t % FRAME) == FRAME - 1) ? 4'd1 : 4'd0);
        checks++;
        if (!$onehot0(~an_now)) begin
            errors++;
            $display("FAIL one_anode t=%0d actual=%b required=at most one low", t, an_now);
        end
    endtask

    task automatic model_reset();
        t = 0;
        mchar = 4'd0;
        moff = 0;
        mfc = 0;
        for (int i = 0; i < ML; i++) mbuf[i] = 4'd0;
    endtask

    task automatic tick();
        int p, pn;
        p = t % FRAME;
        if (!scroll_en) begin
            mfc = 0;
        end else if (p == FRAME - 1) begin
            mfc++;
            if (mfc == SF) begin
                moff = (moff + 1) % ML;
                mfc = 0;
            end
        end
        pn = (t + 1) % FRAME;
        if ((pn % SLOT) == 0) mchar = mbuf[(moff + pn / SLOT) % ML];
        if (wr_en) mbuf[wr_addr] = wr_data;
        t++;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run_to(input int p);
        int n;
        n = 0;
        while ((t % FRAME) != p && n < FRAME + 2) begin
            tick();
            n++;
        end
        checks++;
        if ((t % FRAME) != p) begin
            errors++;
            $display("FAIL run_to actual=%0d required=%0d", t % FRAME, p);
        end
    endtask

    task automatic next_frame();
        run_to(FRAME - 1);
        tick();
    endtask

    task automatic check_frame(input logic [3:0] c3, input logic [3:0] c2,
                               input logic [3:0] c1, input logic [3:0] c0);
        run_to(2);
        check("digit3_char", char, c3);
        check("digit3_an", anodes(), 4'b0111);
        run_to(8);
        check("digit2_char", char, c2);
        run_to(14);
        check("digit1_char", char, c1);
        run_to(20);
        check("digit0_char", char, c0);
        check("digit0_an", anodes(), 4'b1110);
    endtask

    initial begin
        tbl[0]  = '{0,  4'hF, 4'd1, 1'b0};
        tbl[1]  = '{1,  4'hF, 4'd1, 1'b0};
        tbl[2]  = '{2,  4'h7, 4'd1, 1'b0};
        tbl[3]  = '{5,  4'h7, 4'd1, 1'b0};
        tbl[4]  = '{6,  4'hF, 4'd2, 1'b0};
        tbl[5]  = '{8,  4'hB, 4'd2, 1'b0};
        tbl[6]  = '{11, 4'hB, 4'd2, 1'b0};
        tbl[7]  = '{12, 4'hF, 4'd3, 1'b0};
        tbl[8]  = '{14, 4'hD, 4'd3, 1'b0};
        tbl[9]  = '{18, 4'hF, 4'd4, 1'b0};
        tbl[10] = '{20, 4'hE, 4'd4, 1'b0};
        tbl[11] = '{23, 4'hE, 4'd4, 1'b1};

        reset = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        scroll_en = 1'b0;
        model_reset();

        #12;
        check("reset_an", anodes(), 4'hF);
        check("reset_char", char, 4'd0);
        check("reset_tick", {3'b000, frame_tick}, 4'd0);

        @(posedge clk);
        #1;
        reset = 1'b1;
        check_all();

        // Static display: buf[0..3] = 1..4, checked over two frames.
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_addr = 3'(i);
            wr_data = 4'(i + 1);
            tick();
        end
        wr_en = 1'b0;
        while (t < FRAME) tick();
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 12; k++) begin
                run_to(tbl[k].pos);
                check("tbl_an", anodes(), tbl[k].an);
                check("tbl_char", char, tbl[k].ch);
                check("tbl_tick", {3'b000, frame_tick}, {3'b000, tbl[k].ft});
            end
        end

        // Write to buf[1] on the edge that latches digit 2.
        run_to(5);
        wr_en = 1'b1;
        wr_addr = 3'd1;
        wr_data = 4'd9;
        tick();
        wr_en = 1'b0;
        check("same_edge_old", char, 4'd2);
        run_to(8);
        check("same_edge_old_on", char, 4'd2);
        run_to(6);
        check("same_edge_new", char, 4'd9);

        // Scrolling over buf = 0..7.
        for (int i = 0; i < ML; i++) begin
            wr_en = 1'b1;
            wr_addr = 3'(i);
            wr_data = 4'(i);
            tick();
        end
        wr_en = 1'b0;
        run_to(0);
        scroll_en = 1'b1;
        next_frame();
        next_frame();
        check_frame(4'd1, 4'd2, 4'd3, 4'd4);
        for (int f = 0; f < 12; f++) next_frame();
        check_frame(4'd7, 4'd0, 4'd1, 4'd2);

        // scroll_en low for one frame after one counted frame.
        next_frame();
        scroll_en = 1'b0;
        next_frame();
        scroll_en = 1'b1;
        check_frame(4'd7, 4'd0, 4'd1, 4'd2);
        next_frame();
        check_frame(4'd7, 4'd0, 4'd1, 4'd2);
        next_frame();
        check_frame(4'd0, 4'd1, 4'd2, 4'd3);

        // Random writes and scroll toggling against the model.
        for (int i = 0; i < 1500; i++) begin
            wr_en = ($urandom_range(3) == 0);
            wr_addr = 3'($urandom_range(ML - 1));
            wr_data = 4'($urandom_range(15));
            if ($urandom_range(63) == 0) scroll_en = ~scroll_en;
            tick();
        end
        wr_en = 1'b0;
        scroll_en = 1'b0;

        // Async reset during digit 1 ON.
        run_to(15);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_an", anodes(), 4'hF);
        check("async_rst_char", char, 4'd0);
        check("async_rst_tick", {3'b000, frame_tick}, 4'd0);
        @(posedge clk);
        #1;
        check("held_rst_an", anodes(), 4'hF);
        reset = 1'b1;
        model_reset();
        check_all();
        tick();
        tick();
        check("post_rst_an3", anodes(), 4'b0111);
        check("post_rst_char", char, 4'd0);
        for (int i = 0; i < FRAME + 4; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_scan_scheduler.md
Name: led_scan_scheduler

Overview:
Time-multiplexing scheduler for the four-digit 7-segment display. It owns a MSG_LEN-entry character buffer and produces the active-low anode strobes and the 4-bit character code for the existing LED decoder. Each digit gets a fixed dead-time (blanking) slot before it is lit, to suppress ghosting. An optional scroll mode rotates a 4-character window through the buffer. It sits between the debounced reset/clock domain and the LED decoder, and replaces the free-running digit FSM.

Parameters:
DIGIT_CYCLES, 64, clk cycles a digit's anode is held low (>=1)
BLANK_CYCLES, 4, clk cycles all anodes are high before each digit (>=1)
SCROLL_FRAMES, 16, full scan frames per scroll step (>=1)
MSG_LEN, 16, buffer depth in characters; power of 2, >=4
AW, log2(MSG_LEN), buffer address width (derived)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
wr_en  in  1  buffer write strobe, one write per cycle
wr_addr  in  AW  buffer write address
wr_data  in  4  character code written
scroll_en  in  1  1 = advance window every SCROLL_FRAMES frames
an3, an2, an1, an0  out  1 each  anode enables, active-low; an3 = leftmost
char  out  4  character code for the LED decoder
frame_tick  out  1  one-cycle pulse at the end of each full scan frame

Behaviour:
- Reset (reset=0, async): all buffer entries = 0; offset = 0; phase = BLANK; digit index = 3; phase counter = 0; frame counter = 0; an3..an0 = 1111; char = 0; frame_tick = 0.
- FSM per digit, two states:
  - BLANK: lasts BLANK_CYCLES cycles, all anodes high.
  - ON: lasts DIGIT_CYCLES cycles, only the selected anode low.
  - BLANK -> ON when the phase counter reaches BLANK_CYCLES-1.
  - ON -> BLANK when it reaches DIGIT_CYCLES-1. On this transition the digit index decrements 3 -> 2 -> 1 -> 0 -> 3.
- char is registered on the clock edge that enters BLANK for digit k: char <= buf[(offset + (3-k)) mod MSG_LEN]. It is stable through BLANK and ON, so the char setup time before the anode is BLANK_CYCLES.
- On the first cycle after reset release: BLANK for digit 3, with char = buf[offset]. The first anode (an3) falls at cycle BLANK_CYCLES.
- Frame = 4*(BLANK_CYCLES+DIGIT_CYCLES) cycles. frame_tick = 1 on the last ON cycle of digit 0.
- Scroll:
  - While scroll_en=1, the frame counter increments on each frame_tick.
  - At count SCROLL_FRAMES-1 with frame_tick: offset <= (offset+1) mod MSG_LEN (natural AW-bit wrap) and the frame counter clears.
  - scroll_en=0 clears the frame counter and holds offset.
  - The new offset first affects the char latch for digit 3 of the next frame, so there is never a torn frame.
- Writes:
  - buf[wr_addr] <= wr_data on the edge where wr_en=1.
  - A write and a char latch of the same address on the same edge: the latch takes the old value; the new value appears at that digit's next latch.
  - Writes never stall the scan and have no ready signal.
- Anodes are registered outputs: no combinational path from any input to any output.
- Async reset asserted mid-frame forces all outputs to reset values immediately.
- Counter widths: phase counter sized for max(BLANK_CYCLES, DIGIT_CYCLES); frame counter sized for SCROLL_FRAMES.

Decomposition:
- Shared package:
  - phase enum {PH_BLANK, PH_ON}
  - ANODES_OFF = 4'b1111
  - one-hot active-low anode pattern function of the digit index
  - CHAR_W = 4
- One sub-module, msg_buffer: MSG_LEN x 4 register file with one write port, one async read port and async active-low clear.
- Scheduler FSM, counters and output registers live in led_scan_scheduler.

Test Plan:
1. Params DIGIT_CYCLES=4, BLANK_CYCLES=2, MSG_LEN=8; write buf[0..3] = 1,2,3,4; scroll_en=0.
   -> Anodes: 1111 for 2 cycles, then 0111 for 4 cycles (char=1); then 1111 x2, 1011 x4 (char=2); then 1101 (char=3), 1110 (char=4).
   -> frame_tick every 24 cycles; sequence repeats unchanged.
2. SCROLL_FRAMES=2, buf = 0..7, scroll_en=1.
   -> After 2 frames, digit 3 shows 1 and digits 2..0 show 2, 3, 4. After 14 frames, offset=7 and digits show 7, 0, 1, 2 (wrap).
3. Write buf[1]=9 on the same edge char latches buf[1] for digit 2.
   -> That digit shows the old value this frame and 9 in the next frame.
4. Assert reset during the ON phase of digit 1.
   -> Same cycle: anodes 1111, char 0.
   -> After release: 2-cycle blank, then an3 low with char = buf[0] = 0 (buffer cleared).
5. scroll_en pulsed low for 1 frame mid-count (SCROLL_FRAMES=2).
   -> Frame counter restarts; the next offset step occurs 2 full frames after scroll_en returns high.
6. Any cycle, any stimulus.
   -> Never more than one anode low at once, and anodes are never low during BLANK (checked by assertion).
